// File: rtl/cpa_arb_pkg.sv
// Shared defaults and helpers for the round-robin CPA arbiter.
// Width of the requester index is derived from the requester count.
package cpa_arb_pkg;

    localparam int CPA_WIDTH = 15;
    localparam int CPA_NREQ  = 4;

    // A single requester still needs a one-bit index field.
    function automatic int cpa_idw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cpa_prefix_adder.sv
// Parallel-prefix (Kogge-Stone) carry-propagate adder: {cout, sum} = a + b.
// Purely combinational; used as the single shared final adder.
module cpa_prefix_adder #(
    parameter int WIDTH = 15
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LV = (WIDTH < 2) ? 1 : $clog2(WIDTH);

    logic [WIDTH-1:0] w_p0;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g_nx;
    logic [WIDTH-1:0] w_p_nx;

    // Each level doubles the span of the group generate/propagate terms.
    always_comb begin
        w_p0   = a ^ b;
        w_g    = a & b;
        w_p    = w_p0;
        w_g_nx = w_g;
        w_p_nx = w_p;
        for (int l = 0; l < LV; l++) begin
            w_g_nx = w_g;
            w_p_nx = w_p;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << l)) begin
                    w_g_nx[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
                    w_p_nx[i] = w_p[i] & w_p[i - (1 << l)];
                end
            end
            w_g = w_g_nx;
            w_p = w_p_nx;
        end
        sum[0] = w_p0[0];
        for (int i = 1; i < WIDTH; i++) begin
            sum[i] = w_p0[i] ^ w_g[i-1];
        end
        cout = w_g[WIDTH-1];
    end

endmodule

// File: rtl/cpa_rr_grant.sv
// Rotating-priority picker: first set bit of req at or above ptr, with wrap.
// Produces one-hot and encoded grant plus an any-request flag.
module cpa_rr_grant
    import cpa_arb_pkg::*;
#(
    parameter  int NREQ = CPA_NREQ,
    localparam int IDW  = cpa_idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                gnt                            = '0;
                gnt[(int'(ptr) + k) % NREQ]    = 1'b1;
                gnt_id                         = IDW'((int'(ptr) + k) % NREQ);
                any                            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpa_rr_arbiter.sv
// Round-robin arbiter sharing one carry-propagate adder among NREQ requesters.
// The sum is registered and returned on a valid/ready port tagged with the index.
module cpa_rr_arbiter
    import cpa_arb_pkg::*;
#(
    parameter  int WIDTH = CPA_WIDTH,
    parameter  int NREQ  = CPA_NREQ,
    localparam int IDW   = cpa_idw(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_cout,
    output logic [IDW-1:0]        res_id
);

    logic [IDW-1:0]   r_rr_ptr;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_sum;
    logic             r_res_cout;
    logic [IDW-1:0]   r_res_id;

    logic             w_free;
    logic [NREQ-1:0]  w_req;
    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_accept;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    // A drain in the same cycle frees the slot, so back-to-back accepts never bubble.
    assign w_free = !r_res_valid || res_ready;
    assign w_req  = req_valid & {NREQ{w_free}};

    cpa_rr_grant #(
        .NREQ   (NREQ)
    ) u_grant (
        .req    (w_req),
        .ptr    (r_rr_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id),
        .any    (w_accept)
    );

    assign req_ready = w_gnt;

    // One-hot AND-OR operand select; zero operands when nothing is granted.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_op_a = w_op_a | req_a[i*WIDTH +: WIDTH];
                w_op_b = w_op_b | req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    cpa_prefix_adder #(
        .WIDTH (WIDTH)
    ) u_cpa (
        .a     (w_op_a),
        .b     (w_op_b),
        .sum   (w_sum),
        .cout  (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_cout  <= 1'b0;
            r_res_id    <= '0;
        end else if (w_accept) begin
            r_rr_ptr    <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
            r_res_valid <= 1'b1;
            r_res_sum   <= w_sum;
            r_res_cout  <= w_cout;
            r_res_id    <= w_gnt_id;
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_cout  = r_res_cout;
    assign res_id    = r_res_id;

endmodule

// File: tb/tb_cpa_rr_arbiter.sv
// Bench for cpa_rr_arbiter: directed scenarios plus random traffic checked
// against a transaction-level round-robin/arithmetic reference model.
module tb_cpa_rr_arbiter;

    localparam int WIDTH = 15;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_cout;
    logic [IDW-1:0]        res_id;

    cpa_rr_arbiter #(
        .WIDTH     (WIDTH),
        .NREQ      (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: next requester to consider, plus the pending result.
    int m_ptr   = 0;
    int m_valid = 0;
    int m_sum   = 0;
    int m_cout  = 0;
    int m_id    = 0;
    int last_g  = -1;
    int n_dut_del = 0;
    int n_mod_del = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int opa(input int i);
        return int'(req_a[i*WIDTH +: WIDTH]);
    endfunction

    function automatic int opb(input int i);
        return int'(req_b[i*WIDTH +: WIDTH]);
    endfunction

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*WIDTH +: WIDTH] = a[WIDTH-1:0];
        req_b[i*WIDTH +: WIDTH] = b[WIDTH-1:0];
        req_valid[i] = 1'b1;
    endtask

    task automatic check_outputs();
        chk("res_valid", {31'd0, res_valid}, m_valid);
        chk("res_sum",   {17'd0, res_sum},   m_sum);
        chk("res_cout",  {31'd0, res_cout},  m_cout);
        chk("res_id",    {30'd0, res_id},    m_id);
    endtask

    // One clock: check the grant before the edge, advance the model, check results after.
    task automatic cycle();
        int g;
        int s;
        #1;
        g = -1;
        if (m_valid == 0 || res_ready) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        chk("req_ready", {28'd0, req_ready}, (g < 0) ? 0 : (1 << g));
        if (res_valid && res_ready) n_dut_del++;
        if (m_valid != 0 && res_ready) n_mod_del++;
        last_g = g;
        @(posedge clk);
        if (g >= 0) begin
            s       = opa(g) + opb(g);
            m_sum   = s % (1 << WIDTH);
            m_cout  = s >> WIDTH;
            m_id    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % NREQ;
            $display("acc id=%0d a=0x%04h b=0x%04h sum=0x%04h cout=%0d", g, opa(g), opb(g), m_sum, m_cout);
        end else if (m_valid != 0 && res_ready) begin
            m_valid = 0;
        end
        #1;
        check_outputs();
    endtask

    // Mid-cycle reset: outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        req_valid = '0;
        rst = 1'b1;
        #1;
        m_ptr = 0; m_valid = 0; m_sum = 0; m_cout = 0; m_id = 0;
        check_outputs();
        chk("rst_req_ready", {28'd0, req_ready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        #1;
        check_outputs();
        chk("reset_req_ready", {28'd0, req_ready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request with carry-out.
        set_req(0, 'h7FFF, 'h0001);
        cycle();
        req_valid = '0;
        chk("single_sum",  {17'd0, res_sum},  0);
        chk("single_cout", {31'd0, res_cout}, 1);
        chk("single_id",   {30'd0, res_id},   0);
        chk("single_vld",  {31'd0, res_valid}, 1);
        cycle();

        // All requesters continuously valid: strict rotation, one result per cycle.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 'h0100);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rot_id",  {30'd0, res_id},  k % NREQ);
            chk("rot_sum", {17'd0, res_sum}, 'h0101 + (k % NREQ));
        end
        req_valid = '0;
        cycle();

        // Backpressure: held result, no grants, then same-cycle accept on release.
        set_req(2, 'h1234, 'h4321);
        res_ready = 1'b0;
        cycle();
        set_req(2, 'h0001, 'h0002);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_sum",   {17'd0, res_sum},   'h5555);
            chk("bp_ready", {28'd0, req_ready}, 0);
        end
        res_ready = 1'b1;
        cycle();
        chk("bp_next_sum", {17'd0, res_sum}, 3);
        req_valid = '0;
        cycle();

        // Pointer at 3 with requests 1 and 3: 3 first, then wrap to 1.
        do_reset();
        set_req(2, 5, 6);
        cycle();
        req_valid = '0;
        set_req(1, 'h0010, 'h0001);
        set_req(3, 'h0030, 'h0003);
        cycle();
        chk("wrap_first", {30'd0, res_id}, 3);
        req_valid[3] = 1'b0;
        cycle();
        chk("wrap_second", {30'd0, res_id}, 1);
        req_valid = '0;

        // Reset while a result is stalled.
        res_ready = 1'b0;
        set_req(2, 'h0100, 'h0200);
        cycle();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 7 * i + 1, 3);
        cycle();
        chk("post_rst_id", {30'd0, res_id}, 0);
        req_valid = '0;
        res_ready = 1'b1;
        cycle();

        // Random traffic; requesters hold operands until accepted.
        for (int n = 0; n < 400; n++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, int'($urandom_range(0, 32767)), int'($urandom_range(0, 32767)));
            end
            cycle();
            if (last_g >= 0) req_valid[last_g] = 1'b0;
        end
        req_valid = '0;
        res_ready = 1'b1;
        cycle();
        cycle();
        chk("deliveries", n_dut_del, n_mod_del);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
